zombie_referee: RTL and testbench

- Downstream partner of the zombie-hit game core: consumes its `hit`/`fail` outcome strobes and drives its `end_flag` input.
- Runs the round state machine, a BCD score, a BCD seconds countdown and a miss budget.
- Time-multiplexes score and time onto a 4-digit active-low 7-segment display.
- Sits between the game core and the board display pins.

---
 rtl/zombie_pkg.sv | 56 +++++
 rtl/bcd_to_seg7.sv | 28 ++
 rtl/zombie_referee.sv | 154 +++++++++++++++
 tb/tb_zombie_referee.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/zombie_pkg.sv
// zombie_pkg: shared types and constants for the zombie referee.
//   state_t   round state (IDLE, PLAY, OVER)
//   bcd_t     one BCD digit
//   SEG_*     active-low 7-segment glyphs {g,f,e,d,c,b,a}
//   helpers   2-digit BCD increment/decrement/add with saturation
package zombie_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int unsigned BONUS_SECONDS = 2;

  function automatic logic [7:0] to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    if (v == 8'h99)      return v;
    if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // n must be a single digit (0..9); result saturates at 99.
  function automatic logic [7:0] bcd_add_sat(input logic [7:0] v, input int unsigned n);
    logic [4:0] o;
    o = {1'b0, v[3:0]} + 5'(n);
    if (o > 5'd9) begin
      if (v[7:4] == 4'd9) return 8'h99;
      return {v[7:4] + 4'd1, 4'(o - 5'd10)};
    end
    return {v[7:4], o[3:0]};
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD digit to active-low 7-segment glyph.
//   bcd    in  4  digit 0..9 (10..15 show blank)
//   seg_n  out 7  segments {g,f,e,d,c,b,a}, active-low
module bcd_to_seg7
  import zombie_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    case (bcd)
      4'd0: seg_n = SEG_0;
      4'd1: seg_n = SEG_1;
      4'd2: seg_n = SEG_2;
      4'd3: seg_n = SEG_3;
      4'd4: seg_n = SEG_4;
      4'd5: seg_n = SEG_5;
      4'd6: seg_n = SEG_6;
      4'd7: seg_n = SEG_7;
      4'd8: seg_n = SEG_8;
      4'd9: seg_n = SEG_9;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/zombie_referee.sv
// zombie_referee: round referee for the zombie-hit game core.
// Runs the IDLE/PLAY/OVER round machine, a BCD score, a BCD seconds
// countdown and a miss budget, and scans score/time onto a 4-digit
// active-low 7-segment display.
//   clock       in   system clock
//   reset       in   asynchronous active-low reset
//   start       in   one-cycle start pulse (ignored during PLAY)
//   hit         in   hit strobe level, rising edge scores
//   fail        in   wrong-press level, rising edge costs one miss
//   end_flag    out  1 when no round is in play
//   score_bcd   out  {tens,ones} BCD hits this round
//   time_bcd    out  {tens,ones} BCD seconds remaining
//   fails_left  out  remaining miss budget
//   an_n        out  active-low one-hot digit enable
//   seg_n       out  active-low segments {dp,g,f,e,d,c,b,a}
// Build option: define BONUS_TIME_EN to add BONUS_SECONDS to the clock on
// every hit that lands the score on a multiple of ten.
module zombie_referee
  import zombie_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50000000,
  parameter int unsigned GAME_SECONDS = 30,
  parameter int unsigned MAX_FAILS    = 3,
  parameter int unsigned SCAN_DIV     = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       hit,
  input  logic       fail,
  output logic       end_flag,
  output logic [7:0] score_bcd,
  output logic [7:0] time_bcd,
  output logic [1:0] fails_left,
  output logic [3:0] an_n,
  output logic [7:0] seg_n
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [7:0]    GAME_BCD  = to_bcd(GAME_SECONDS);
  localparam logic [1:0]    MAX_F     = 2'(MAX_FAILS);

  state_t        state_q, state_d;
  logic          hit_d, fail_d;
  logic [7:0]    score_d, time_d, time_tmp;
  logic [1:0]    fails_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    slot_q, slot_d;
  bcd_t          digit;
  logic [6:0]    glyph;
  logic          hit_rise, fail_rise;

  assign hit_rise  = hit & ~hit_d;
  assign fail_rise = fail & ~fail_d;

  // Round machine. Hit takes priority over a same-edge fail; the countdown
  // and any bonus are folded into time_tmp before the expiry test so that
  // a bonus on the expiry edge keeps the round alive.
  always_comb begin
    state_d  = state_q;
    score_d  = score_bcd;
    time_d   = time_bcd;
    fails_d  = fails_left;
    tick_d   = '0;
    time_tmp = time_bcd;
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d = PLAY;
          score_d = '0;
          time_d  = GAME_BCD;
          fails_d = MAX_F;
        end
      end
      PLAY: begin
        tick_d = tick_q + TW'(1);
        if (tick_q == TICK_LAST) begin
          tick_d   = '0;
          time_tmp = bcd_dec(time_bcd);
        end
        if (hit_rise) begin
          score_d = bcd_inc_sat(score_bcd);
`ifdef BONUS_TIME_EN
          if (score_bcd != 8'h99 && score_d[3:0] == 4'd0)
            time_tmp = bcd_add_sat(time_tmp, BONUS_SECONDS);
`endif
        end else if (fail_rise) begin
          fails_d = fails_left - 2'd1;
        end
        time_d = time_tmp;
        if (time_tmp == 8'h00 || fails_d == 2'd0)
          state_d = OVER;
      end
      default: state_d = IDLE;
    endcase
  end

  // Display scan: the slot and the shown digit are derived from next-state
  // values so an_n and seg_n register together with the data they show.
  always_comb begin
    scan_d = scan_q + SW'(1);
    slot_d = slot_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      slot_d = slot_q + 2'd1;
    end
    case (slot_d)
      2'd0:    digit = score_d[7:4];
      2'd1:    digit = score_d[3:0];
      2'd2:    digit = time_d[7:4];
      default: digit = time_d[3:0];
    endcase
  end

  bcd_to_seg7 u_seg (
    .bcd   (digit),
    .seg_n (glyph)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      end_flag   <= 1'b1;
      score_bcd  <= '0;
      time_bcd   <= GAME_BCD;
      fails_left <= MAX_F;
      tick_q     <= '0;
      scan_q     <= '0;
      slot_q     <= '0;
      an_n       <= 4'b1110;
      seg_n      <= {1'b1, SEG_0};
      hit_d      <= 1'b0;
      fail_d     <= 1'b0;
    end else begin
      state_q    <= state_d;
      end_flag   <= (state_d != PLAY);
      score_bcd  <= score_d;
      time_bcd   <= time_d;
      fails_left <= fails_d;
      tick_q     <= tick_d;
      scan_q     <= scan_d;
      slot_q     <= slot_d;
      an_n       <= ~(4'b0001 << slot_d);
      seg_n      <= {~(slot_d == 2'd1 && state_d == PLAY), glyph};
      hit_d      <= hit;
      fail_d     <= fail;
    end
  end

endmodule

// File: tb/tb_zombie_referee.sv
module tb_zombie_referee;

  logic clock = 1'b0;
  logic reset, start, hit, fail;
  logic start2, hit2, fail2;

  logic       end_flag, end_flag2;
  logic [7:0] score_bcd, score_bcd2, time_bcd, time_bcd2;
  logic [1:0] fails_left, fails_left2;
  logic [3:0] an_n, an_n2;
  logic [7:0] seg_n, seg_n2;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;

  always #5 clock = ~clock;

  // Short round: countdown, display and reset scenarios.
  zombie_referee #(.TICK_DIV(10), .GAME_SECONDS(3), .MAX_FAILS(3), .SCAN_DIV(4)) dut (
    .clock(clock), .reset(reset), .start(start), .hit(hit), .fail(fail),
    .end_flag(end_flag), .score_bcd(score_bcd), .time_bcd(time_bcd),
    .fails_left(fails_left), .an_n(an_n), .seg_n(seg_n)
  );

  // Long round: room for 100+ hits and a 50-cycle fail hold.
  zombie_referee #(.TICK_DIV(10), .GAME_SECONDS(50), .MAX_FAILS(3), .SCAN_DIV(4)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .hit(hit2), .fail(fail2),
    .end_flag(end_flag2), .score_bcd(score_bcd2), .time_bcd(time_bcd2),
    .fails_left(fails_left2), .an_n(an_n2), .seg_n(seg_n2)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    n_tests++; if (end_flag !== 1'b1) begin n_fail++; $display("FAIL rst_end_flag got %b want 1", end_flag); end
    n_tests++; if (score_bcd !== 8'h00) begin n_fail++; $display("FAIL rst_score got %h want 00", score_bcd); end
    n_tests++; if (time_bcd !== 8'h03) begin n_fail++; $display("FAIL rst_time got %h want 03", time_bcd); end
    n_tests++; if (fails_left !== 2'd3) begin n_fail++; $display("FAIL rst_fails got %0d want 3", fails_left); end
    n_tests++; if (an_n !== 4'b1110) begin n_fail++; $display("FAIL rst_an got %b want 1110", an_n); end
    n_tests++; if (seg_n !== 8'hC0) begin n_fail++; $display("FAIL rst_seg got %h want c0", seg_n); end
    n_tests++; if (time_bcd2 !== 8'h50) begin n_fail++; $display("FAIL rst_time2 got %h want 50", time_bcd2); end
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      int slot;
      logic [3:0] ea;
      slot = (k / 4) % 4;
      ea = ~(4'b0001 << slot);
      exp_q.push_back({4'b0, ea});
      exp_q.push_back(slot == 3 ? 8'hB0 : 8'hC0);
      tick();
      e = exp_q.pop_front();
      n_tests++; if (an_n !== e[3:0]) begin n_fail++; $display("FAIL scan_an k=%0d got %b want %b", k, an_n, e[3:0]); end
      e = exp_q.pop_front();
      n_tests++; if (seg_n !== e) begin n_fail++; $display("FAIL scan_seg k=%0d got %h want %h", k, seg_n, e); end
    end
  endtask

  task automatic test_countdown();
    start = 1'b1; tick(); start = 1'b0;
    n_tests++; if (end_flag !== 1'b0) begin n_fail++; $display("FAIL cd_enter end_flag got %b want 0", end_flag); end
    n_tests++; if (time_bcd !== 8'h03) begin n_fail++; $display("FAIL cd_enter time got %h want 03", time_bcd); end
    for (int c = 1; c <= 30; c++) begin
      exp_q.push_back(8'(3 - c / 10));
      exp_q.push_back({7'b0, c == 30});
      tick();
      e = exp_q.pop_front();
      n_tests++; if (time_bcd !== e) begin n_fail++; $display("FAIL cd_time c=%0d got %h want %h", c, time_bcd, e); end
      e = exp_q.pop_front();
      n_tests++; if (end_flag !== e[0]) begin n_fail++; $display("FAIL cd_end c=%0d got %b want %b", c, end_flag, e[0]); end
    end
    repeat (2) begin hit = 1'b1; tick(); hit = 1'b0; tick(); end
    n_tests++; if (score_bcd !== 8'h00) begin n_fail++; $display("FAIL over_hit score got %h want 00", score_bcd); end
    n_tests++; if (time_bcd !== 8'h00) begin n_fail++; $display("FAIL over_freeze time got %h want 00", time_bcd); end
  endtask

  task automatic test_dp();
    int n;
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (an_n !== 4'b1101 && n < 8) begin tick(); n++; end
    n_tests++;
    if (an_n !== 4'b1101) begin n_fail++; $display("FAIL dp_wait an got %b want 1101", an_n); end
    else if (seg_n !== 8'h40) begin n_fail++; $display("FAIL dp_slot1 seg got %h want 40", seg_n); end
    n = 0;
    while (an_n !== 4'b1011 && n < 8) begin tick(); n++; end
    n_tests++;
    if (an_n !== 4'b1011) begin n_fail++; $display("FAIL dp_wait2 an got %b want 1011", an_n); end
    else if (seg_n !== 8'hC0) begin n_fail++; $display("FAIL dp_slot2 seg got %h want c0", seg_n); end
    n = 0;
    while (end_flag !== 1'b1 && n < 40) begin tick(); n++; end
    n_tests++; if (end_flag !== 1'b1) begin n_fail++; $display("FAIL dp_end end_flag got %b want 1", end_flag); end
  endtask

  task automatic test_hit_fail_reset();
    int n;
    start = 1'b1; tick(); start = 1'b0;
    hit = 1'b1; fail = 1'b1; tick();
    n_tests++; if (score_bcd !== 8'h01) begin n_fail++; $display("FAIL same_score got %h want 01", score_bcd); end
    n_tests++; if (fails_left !== 2'd3) begin n_fail++; $display("FAIL same_fails got %0d want 3", fails_left); end
    hit = 1'b0; fail = 1'b0; tick();
    repeat (4) begin hit = 1'b1; tick(); hit = 1'b0; tick(); end
    n_tests++; if (score_bcd !== 8'h05) begin n_fail++; $display("FAIL pre_rst score got %h want 05", score_bcd); end
    #2 reset = 1'b0;
    #1;
    n_tests++; if (end_flag !== 1'b1) begin n_fail++; $display("FAIL midrst end_flag got %b want 1", end_flag); end
    n_tests++; if (score_bcd !== 8'h00) begin n_fail++; $display("FAIL midrst score got %h want 00", score_bcd); end
    n_tests++; if (time_bcd !== 8'h03) begin n_fail++; $display("FAIL midrst time got %h want 03", time_bcd); end
    n_tests++; if (fails_left !== 2'd3) begin n_fail++; $display("FAIL midrst fails got %0d want 3", fails_left); end
    @(negedge clock);
    reset = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    n_tests++; if (end_flag !== 1'b0) begin n_fail++; $display("FAIL fresh end_flag got %b want 0", end_flag); end
    n_tests++; if ({score_bcd, time_bcd} !== 16'h0003) begin n_fail++; $display("FAIL fresh score/time got %h want 0003", {score_bcd, time_bcd}); end
    n = 0;
    while (end_flag !== 1'b1 && n < 40) begin tick(); n++; end
    n_tests++; if (end_flag !== 1'b1) begin n_fail++; $display("FAIL fresh_end end_flag got %b want 1", end_flag); end
  endtask

  task automatic test_expiry_hit();
    start = 1'b1; tick(); start = 1'b0;
    repeat (29) tick();
    hit = 1'b1; tick(); hit = 1'b0;
    n_tests++; if (score_bcd !== 8'h01) begin n_fail++; $display("FAIL exp_hit score got %h want 01", score_bcd); end
    n_tests++; if (end_flag !== 1'b1) begin n_fail++; $display("FAIL exp_hit end_flag got %b want 1", end_flag); end
    n_tests++; if (time_bcd !== 8'h00) begin n_fail++; $display("FAIL exp_hit time got %h want 00", time_bcd); end
  endtask

  task automatic test_hits();
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (int k = 1; k <= 105; k++) begin
      int v;
      v = (k > 99) ? 99 : k;
      exp_q.push_back({4'(v / 10), 4'(v % 10)});
      hit2 = 1'b1; tick();
      e = exp_q.pop_front();
      n_tests++; if (score_bcd2 !== e) begin n_fail++; $display("FAIL hits k=%0d score got %h want %h", k, score_bcd2, e); end
      hit2 = 1'b0; tick();
      if (k == 12) begin
`ifdef BONUS_TIME_EN
        e = 8'h50;
`else
        e = 8'h48;
`endif
        n_tests++; if (time_bcd2 !== e) begin n_fail++; $display("FAIL hits_time got %h want %h", time_bcd2, e); end
      end
    end
  endtask

  task automatic test_fail();
    fail2 = 1'b1; tick();
    n_tests++; if (fails_left2 !== 2'd2) begin n_fail++; $display("FAIL held_first got %0d want 2", fails_left2); end
    repeat (49) tick();
    n_tests++; if (fails_left2 !== 2'd2) begin n_fail++; $display("FAIL held_once got %0d want 2", fails_left2); end
    n_tests++; if (end_flag2 !== 1'b0) begin n_fail++; $display("FAIL held end_flag got %b want 0", end_flag2); end
    fail2 = 1'b0; tick();
    fail2 = 1'b1; tick(); fail2 = 1'b0;
    n_tests++; if (fails_left2 !== 2'd1) begin n_fail++; $display("FAIL second got %0d want 1", fails_left2); end
    tick();
    fail2 = 1'b1; tick(); fail2 = 1'b0;
    n_tests++; if (fails_left2 !== 2'd0) begin n_fail++; $display("FAIL third got %0d want 0", fails_left2); end
    n_tests++; if (end_flag2 !== 1'b1) begin n_fail++; $display("FAIL third end_flag got %b want 1", end_flag2); end
    tick();
    hit2 = 1'b1; tick(); hit2 = 1'b0; tick();
    n_tests++; if (score_bcd2 !== 8'h99) begin n_fail++; $display("FAIL over_freeze score got %h want 99", score_bcd2); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0; hit = 1'b0; fail = 1'b0;
    start2 = 1'b0; hit2 = 1'b0; fail2 = 1'b0;
    test_reset();
    test_countdown();
    test_dp();
    test_hit_fail_reset();
    test_expiry_hit();
    test_hits();
    test_fail();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
